// File: rtl/sw_pkg.sv
// ---------------------------------------------------------------------------
// sw_pkg
// Shared constants and types for the Smith-Waterman sequence loader.
//   RX_BASE / STATUS_BASE : UART register addresses on the Avalon-MM bus
//   RX_OK_BIT / TX_OK_BIT : flag positions inside the UART STATUS word
//   SEQ_LENGTH            : bases per sequence (two bits per base)
//   SEQ_BITS              : width of one packed sequence bus
//   loader_state_e        : state encoding of the loader FSM
// ---------------------------------------------------------------------------
package sw_pkg;

  localparam logic [4:0] RX_BASE     = 5'd0;
  localparam logic [4:0] STATUS_BASE = 5'd8;
  localparam int         RX_OK_BIT   = 7;
  localparam int         TX_OK_BIT   = 6;

  localparam int SEQ_LENGTH = 128;
  localparam int SEQ_BITS   = 2 * SEQ_LENGTH;

  typedef enum logic [1:0] {
    S_POLL = 2'd0,
    S_GET  = 2'd1,
    S_HOLD = 2'd2
  } loader_state_e;

endpackage

// File: rtl/sw_seq_loader_if.sv
// ---------------------------------------------------------------------------
// sw_seq_loader_if
// Avalon-MM read-only link between the sequence loader and the UART core.
//   avm_address     : register address driven by the master
//   avm_read        : read request driven by the master
//   avm_readdata    : read data returned by the slave
//   avm_waitrequest : slave stall; a read completes when this is low
// Modports: master (the loader) and slave (the UART side).
// ---------------------------------------------------------------------------
interface sw_seq_loader_if;

  logic [4:0]  avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_readdata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_readdata,
    output avm_waitrequest
  );

endinterface

// File: rtl/sw_seq_loader.sv
// ---------------------------------------------------------------------------
// sw_seq_loader
// Pulls bytes from a UART over Avalon-MM and assembles them into one
// Smith-Waterman frame: the first half of the bytes form the reference
// sequence and the second half the read sequence, both MSB-first.
// A partial frame that goes idle for TIMEOUT_CYCLES is discarded.
//
// Ports:
//   avm_clk, avm_rst_n   : clock, asynchronous active-low reset
//   avm                  : Avalon-MM master (UART RX / STATUS polling)
//   o_valid / i_ready    : frame handshake towards SW_core
//   o_sequence_ref       : 128 two-bit reference bases
//   o_sequence_read      : 128 two-bit read bases
//   o_seq_ref_length     : constant 128
//   o_seq_read_length    : constant 128
//   o_frame_drop         : one-cycle pulse when a partial frame is dropped
// ---------------------------------------------------------------------------
module sw_seq_loader
  import sw_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FRAME_BYTES    = 64
) (
  input  logic                avm_clk,
  input  logic                avm_rst_n,
  sw_seq_loader_if.master     avm,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [SEQ_BITS-1:0] o_sequence_ref,
  output logic [SEQ_BITS-1:0] o_sequence_read,
  output logic [7:0]          o_seq_ref_length,
  output logic [7:0]          o_seq_read_length,
  output logic                o_frame_drop
);

  localparam int FRAME_BITS = 2 * SEQ_BITS;
  localparam int IDX_W      = $clog2(FRAME_BYTES + 1);
  localparam int CNT_W      = 17;

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(FRAME_BYTES - 1);

  loader_state_e         state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      idle_q, idle_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic                  drop_q, drop_d;

  logic byte_accept;
  logic unused_rdata;

  // Only the low byte of RX and the RX_OK flag of STATUS carry information.
  assign unused_rdata = ^avm.avm_readdata[31:8];

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    idle_d          = idle_q;
    frame_d         = frame_q;
    drop_d          = 1'b0;
    byte_accept     = 1'b0;
    avm.avm_read    = 1'b1;
    avm.avm_address = STATUS_BASE;

    // Bus outputs depend only on the state, and the state only moves once a
    // read has completed, so address/read are stable throughout a stall.
    case (state_q)
      S_POLL: begin
        if (!avm.avm_waitrequest && avm.avm_readdata[RX_OK_BIT]) begin
          state_d = S_GET;
        end
      end

      S_GET: begin
        avm.avm_address = RX_BASE;
        if (!avm.avm_waitrequest) begin
          byte_accept = 1'b1;
          // Frame register is {ref, read}; byte k lands at the top minus 8k.
          for (int k = 0; k < FRAME_BITS / 8; k++) begin
            if (idx_q == IDX_W'(k)) begin
              frame_d[FRAME_BITS-1-8*k -: 8] = avm.avm_readdata[7:0];
            end
          end
          idx_d   = idx_q + IDX_W'(1);
          state_d = (idx_q == LAST_IDX) ? S_HOLD : S_POLL;
        end
      end

      S_HOLD: begin
        avm.avm_read = 1'b0;
        if (i_ready) begin
          state_d = S_POLL;
          idx_d   = '0;
        end
      end

      default: begin
        state_d = S_POLL;
      end
    endcase

    // Entry into S_HOLD always coincides with an accepted byte, so clearing
    // on byte_accept also covers the clear-on-hold-entry case.
    if (byte_accept) begin
      idle_d = '0;
    end else if (idle_q < TIMEOUT_VAL) begin
      idle_d = idle_q + CNT_W'(1);
    end

    // A byte landing in the same cycle always wins over the timeout.
    if (state_q == S_POLL && idle_q == TIMEOUT_VAL && idx_q != '0 && !byte_accept) begin
      idx_d  = '0;
      drop_d = 1'b1;
    end
  end

  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      state_q <= S_POLL;
      idx_q   <= '0;
      idle_q  <= '0;
      frame_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      idle_q  <= idle_d;
      frame_q <= frame_d;
      drop_q  <= drop_d;
    end
  end

  assign o_valid           = (state_q == S_HOLD);
  assign o_frame_drop      = drop_q;
  assign o_sequence_ref    = frame_q[FRAME_BITS-1:SEQ_BITS];
  assign o_sequence_read   = frame_q[SEQ_BITS-1:0];
  assign o_seq_ref_length  = 8'(SEQ_LENGTH);
  assign o_seq_read_length = 8'(SEQ_LENGTH);

endmodule

// File: tb/tb_sw_seq_loader.sv
// ---------------------------------------------------------------------------
// tb_sw_seq_loader
// Drives sw_seq_loader with a behavioural UART slave (byte FIFO, optional
// stalls) and compares every delivered frame with frames assembled from the
// bytes that were queued into the UART.
// ---------------------------------------------------------------------------
module tb_sw_seq_loader;
  import sw_pkg::*;

  localparam int TMO = 100;
  localparam int FB  = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_ready = 1'b0;
  logic         o_valid;
  logic         o_frame_drop;
  logic [255:0] o_ref;
  logic [255:0] o_read;
  logic [7:0]   ref_len;
  logic [7:0]   read_len;

  sw_seq_loader_if bus();

  sw_seq_loader #(
    .TIMEOUT_CYCLES(TMO),
    .FRAME_BYTES   (FB)
  ) dut (
    .avm_clk          (clk),
    .avm_rst_n        (rst_n),
    .avm              (bus),
    .o_valid          (o_valid),
    .i_ready          (i_ready),
    .o_sequence_ref   (o_ref),
    .o_sequence_read  (o_read),
    .o_seq_ref_length (ref_len),
    .o_seq_read_length(read_len),
    .o_frame_drop     (o_frame_drop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // UART slave model state
  logic [7:0]   rx_fifo[$];
  int           stall_rx = 0;
  bit           rand_stall = 1'b0;
  int           stall_left = -1;
  bit           pend_pop = 1'b0;
  bit           prev_wait = 1'b0;
  logic [4:0]   prev_addr = '0;
  logic         prev_read = 1'b0;
  int           rx_pops = 0;
  int           rx_stall_cycles = 0;

  // Observed and expected frames, packed as {ref, read}
  logic [511:0] got_frames[$];
  logic [511:0] exp_frames[$];
  int           valid_cycles = 0;
  int           drop_count = 0;

  task automatic check_output(input string tag, input logic [511:0] observed,
                              input logic [511:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue one full frame of bytes and record the frame it must produce:
  // shifting each byte in from the right leaves byte 0 in the top octet.
  task automatic apply_stimulus(input bit counting, input int base);
    logic [511:0] f;
    logic [7:0]   b;
    f = '0;
    for (int k = 0; k < FB; k++) begin
      b = counting ? 8'(base + k) : 8'($urandom);
      rx_fifo.push_back(b);
      f = {f[503:0], b};
    end
    exp_frames.push_back(f);
  endtask

  task automatic push_partial(input int n);
    for (int k = 0; k < n; k++) rx_fifo.push_back(8'($urandom));
  endtask

  task automatic wait_frames(input int n, input string tag);
    int budget;
    budget = 4000;
    while (got_frames.size() < n && budget > 0) begin
      tick();
      budget--;
    end
    check_output({tag, "_frame_arrived"}, 512'(got_frames.size() >= n), 512'(1));
  endtask

  task automatic wait_fifo_empty(input string tag);
    int budget;
    budget = 2000;
    while (rx_fifo.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    check_output({tag, "_fifo_drained"}, 512'(rx_fifo.size()), 512'(0));
  endtask

  task automatic compare_next_frame(input string tag);
    logic [511:0] g;
    logic [511:0] e;
    if (got_frames.size() > 0 && exp_frames.size() > 0) begin
      g = got_frames.pop_front();
      e = exp_frames.pop_front();
      check_output({tag, "_frame"}, g, e);
    end else begin
      check_output({tag, "_frame_present"}, 512'(got_frames.size()), 512'(1));
    end
  endtask

  // Behavioural UART slave; responses change on the falling edge so the
  // loader samples settled values on the rising edge.
  always @(negedge clk) begin
    logic [31:0] junk;
    junk = $urandom();
    if (!rst_n) begin
      bus.avm_waitrequest = 1'b0;
      bus.avm_readdata    = '0;
      stall_left          = -1;
      pend_pop            = 1'b0;
      prev_wait           = 1'b0;
    end else begin
      if (pend_pop) begin
        if (rx_fifo.size() > 0) void'(rx_fifo.pop_front());
        rx_pops++;
        pend_pop = 1'b0;
      end
      if (prev_wait) begin
        check_output("stall_addr_stable", 512'(bus.avm_address), 512'(prev_addr));
        check_output("stall_read_stable", 512'(bus.avm_read), 512'(prev_read));
      end
      if (bus.avm_read) begin
        if (stall_left < 0) begin
          if (bus.avm_address == RX_BASE) stall_left = stall_rx;
          else stall_left = rand_stall ? int'($urandom_range(0, 2)) : 0;
        end
        if (bus.avm_address == RX_BASE)
          bus.avm_readdata = {junk[31:8], (rx_fifo.size() > 0) ? rx_fifo[0] : 8'h00};
        else
          bus.avm_readdata = {junk[31:8], rx_fifo.size() > 0, junk[6:0]};
        if (stall_left > 0) begin
          bus.avm_waitrequest = 1'b1;
          stall_left--;
          if (bus.avm_address == RX_BASE) rx_stall_cycles++;
        end else begin
          bus.avm_waitrequest = 1'b0;
          stall_left          = -1;
          pend_pop            = (bus.avm_address == RX_BASE);
        end
      end else begin
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdata    = junk;
        stall_left          = -1;
      end
      prev_wait = bus.avm_waitrequest;
      prev_addr = bus.avm_address;
      prev_read = bus.avm_read;
    end
  end

  // Frame/drop monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_valid) valid_cycles++;
      if (o_valid && i_ready) got_frames.push_back({o_ref, o_read});
      if (o_frame_drop) drop_count++;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [511:0] g;
    logic [511:0] snap;
    int           v0;
    int           s0;

    // Reset state
    #3;
    check_output("rst_valid", 512'(o_valid), 512'(0));
    check_output("rst_drop", 512'(o_frame_drop), 512'(0));
    check_output("rst_read", 512'(bus.avm_read), 512'(1));
    check_output("rst_addr", 512'(bus.avm_address), 512'(8));
    check_output("rst_seq", {o_ref, o_read}, 512'(0));
    check_output("ref_len", 512'(ref_len), 512'(128));
    check_output("read_len", 512'(read_len), 512'(128));
    tick();
    tick();
    rst_n   = 1'b1;
    i_ready = 1'b1;

    // Counting frame, no stalls
    $display("[TB] counting frame, no stalls");
    v0 = valid_cycles;
    apply_stimulus(1'b1, 0);
    wait_frames(1, "A");
    if (got_frames.size() > 0) begin
      g = got_frames[0];
      check_output("A_ref_first", 512'(g[511:504]), 512'(8'h00));
      check_output("A_ref_last", 512'(g[263:256]), 512'(8'h1F));
      check_output("A_read_first", 512'(g[255:248]), 512'(8'h20));
      check_output("A_read_last", 512'(g[7:0]), 512'(8'h3F));
    end
    compare_next_frame("A");
    repeat (3) tick();
    check_output("A_valid_one_cycle", 512'(valid_cycles - v0), 512'(1));
    check_output("A_valid_low", 512'(o_valid), 512'(0));

    // Idle with empty index: no drop
    repeat (150) tick();
    check_output("idle_no_drop", 512'(drop_count), 512'(0));

    // Stalled RX reads
    $display("[TB] counting frame, 3-cycle RX stalls");
    stall_rx = 3;
    s0 = rx_stall_cycles;
    apply_stimulus(1'b1, 0);
    wait_frames(1, "B");
    compare_next_frame("B");
    check_output("B_stall_cycles", 512'(rx_stall_cycles - s0), 512'(3 * FB));

    // Partial frame timeout then fresh frame
    $display("[TB] partial frame timeout");
    stall_rx   = 0;
    rand_stall = 1'b1;
    push_partial(10);
    wait_fifo_empty("C");
    repeat (150) tick();
    check_output("C_one_drop", 512'(drop_count), 512'(1));
    apply_stimulus(1'b0, 0);
    wait_frames(1, "C");
    compare_next_frame("C");
    check_output("C_no_extra_drop", 512'(drop_count), 512'(1));

    // Backpressure: i_ready low for 20 valid cycles
    $display("[TB] backpressure hold");
    i_ready  = 1'b0;
    stall_rx = int'($urandom_range(0, 2));
    v0 = valid_cycles;
    apply_stimulus(1'b0, 0);
    begin
      int budget;
      budget = 4000;
      while (!o_valid && budget > 0) begin
        tick();
        budget--;
      end
    end
    check_output("D_valid_seen", 512'(o_valid), 512'(1));
    snap = {o_ref, o_read};
    for (int i = 0; i < 20; i++) begin
      check_output("D_hold_valid", 512'(o_valid), 512'(1));
      check_output("D_hold_noread", 512'(bus.avm_read), 512'(0));
      check_output("D_hold_data", {o_ref, o_read}, snap);
      tick();
    end
    i_ready = 1'b1;
    check_output("D_valid_cycle21", 512'(o_valid), 512'(1));
    tick();
    check_output("D_valid_dropped", 512'(o_valid), 512'(0));
    check_output("D_valid_cycles", 512'(valid_cycles - v0), 512'(21));
    compare_next_frame("D");

    // Reset mid-frame
    $display("[TB] reset after byte 40");
    stall_rx = 0;
    push_partial(40);
    wait_fifo_empty("E");
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check_output("E_rst_valid", 512'(o_valid), 512'(0));
    check_output("E_rst_drop", 512'(o_frame_drop), 512'(0));
    check_output("E_rst_read", 512'(bus.avm_read), 512'(1));
    check_output("E_rst_addr", 512'(bus.avm_address), 512'(8));
    check_output("E_rst_seq", {o_ref, o_read}, 512'(0));
    rx_fifo.delete();
    tick();
    tick();
    rst_n = 1'b1;
    check_output("E_no_frame", 512'(got_frames.size()), 512'(0));
    apply_stimulus(1'b0, 0);
    wait_frames(1, "E");
    compare_next_frame("E");
    check_output("E_no_drop", 512'(drop_count), 512'(1));

    // Back-to-back frames
    $display("[TB] back-to-back frames");
    v0 = valid_cycles;
    apply_stimulus(1'b0, 0);
    apply_stimulus(1'b0, 0);
    wait_frames(2, "F");
    compare_next_frame("F1");
    compare_next_frame("F2");
    tick();
    check_output("F_valid_pulses", 512'(valid_cycles - v0), 512'(2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sw_seq_loader.md
SW_SEQ_LOADER -- requirements
Module: sw_seq_loader

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000, meaning idle cycles mid-frame before a partial frame is discarded.
REQ-002 SHALL have parameter FRAME_BYTES, default 64, meaning bytes per frame: 32 ref plus 32 read.
REQ-003 avm_clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 avm_rst_n  in  1  asynchronous, active-low reset.
REQ-005 avm_address  out  5  UART register address: RX=0, STATUS=8.
REQ-006 avm_read  out  1  Avalon-MM read request.
REQ-007 avm_readdata  in  32  read data; RX byte in [7:0], RX_OK in bit 7 of STATUS.
REQ-008 avm_waitrequest  in  1  slave stall; read completes in the cycle it is low.
REQ-009 o_valid  out  1  frame ready for SW_core.
REQ-010 i_ready  in  1  SW_core accepts the frame.
REQ-011 o_sequence_ref  out  256  128 two-bit bases.
REQ-012 o_sequence_read  out  256  128 two-bit bases.
REQ-013 o_seq_ref_length  out  8  constant 128.
REQ-014 o_seq_read_length  out  8  constant 128.
REQ-015 o_frame_drop  out  1  one-cycle pulse when a partial frame is discarded.

Function
REQ-016 SHALL implement FSM states S_POLL, S_GET, S_HOLD.
REQ-017 S_POLL SHALL drive avm_read=1, avm_address=8.
 - on avm_waitrequest=0 with avm_readdata[7]=1: go to S_GET.
 - otherwise stay in S_POLL.
REQ-018 S_GET SHALL drive avm_read=1, avm_address=0.
 - on avm_waitrequest=0: store avm_readdata[7:0], increment the byte index.
 - then return to S_POLL, or go to S_HOLD if this was byte FRAME_BYTES-1.
REQ-019 Byte placement SHALL be MSB-first.
 - byte k (0..31) goes to o_sequence_ref[255-8k -: 8].
 - byte k (32..63) goes to o_sequence_read[255-8(k-32) -: 8].
REQ-020 avm_address and avm_read SHALL stay constant while avm_waitrequest=1.
REQ-021 S_HOLD SHALL drive avm_read=0 and o_valid=1.
 - o_sequence_* SHALL stay stable while o_valid=1.
REQ-022 The frame SHALL transfer in the cycle where o_valid=1 and i_ready=1.
 - next cycle: o_valid=0, byte index=0, state S_POLL.
 - i_ready while o_valid=0 SHALL have no effect.
REQ-023 o_valid SHALL NOT drop without a transfer, except on reset.
REQ-024 The idle counter (17 bits) SHALL:
 - clear on every accepted byte and on entry to S_HOLD;
 - increment each cycle otherwise, saturating at TIMEOUT_CYCLES.
REQ-025 If the counter reaches TIMEOUT_CYCLES in S_POLL with byte index >0, the block SHALL:
 - reset the byte index to 0;
 - pulse o_frame_drop for one cycle;
 - keep stale sequence bits until they are overwritten.
REQ-026 With byte index =0, timeout SHALL have no effect and SHALL NOT pulse o_frame_drop.
REQ-027 If a byte completes in the same cycle the timeout condition occurs, the byte SHALL win: it is stored and the counter clears.
REQ-028 Sequence-register updates SHALL take effect only on accepted bytes.
REQ-029 The length outputs SHALL be constant 8'd128.

Reset
REQ-030 When avm_rst_n=0 the block SHALL asynchronously set:
 - state=S_POLL, avm_read=1, avm_address=8;
 - o_valid=0, o_frame_drop=0;
 - byte index=0, idle counter=0;
 - o_sequence_ref=0, o_sequence_read=0.
REQ-031 Reset mid-frame or in S_HOLD SHALL discard the frame; no o_frame_drop pulse.

Structure
REQ-032 Package sw_pkg SHALL hold:
 - RX_BASE, STATUS_BASE, RX_OK_BIT, TX_OK_BIT;
 - SEQ_LENGTH=128;
 - the loader state enum type.
REQ-033 The block SHALL be a single module with no sub-module.
 - the idle counter is inline;
 - SW_Wrapper instantiates it in place of its receive logic.

Verification
REQ-034 Bytes 0x00..0x3F, waitrequest=0, i_ready=1 -> o_valid for 1 cycle; o_sequence_ref[255:248]=0x00, [7:0]=0x1F; o_sequence_read[255:248]=0x20, [7:0]=0x3F.
REQ-035 waitrequest held high 3 cycles on each RX read -> frame identical to REQ-034; address/read stable while stalled.
REQ-036 10 bytes, then TIMEOUT_CYCLES=100 idle cycles -> one o_frame_drop pulse; a following 64-byte frame lands with byte 0 at ref[255:248].
REQ-037 i_ready held low 20 cycles after o_valid -> o_valid and data held 20 cycles; no avm_read; transfer on cycle 21.
REQ-038 avm_rst_n low after byte 40 -> all outputs at reset values; a fresh 64-byte frame is then correct.
REQ-039 Two back-to-back frames with i_ready=1 -> two o_valid pulses, second carrying frame-2 data only.
